// File: rtl/axis_buffer_tx.sv
// AXI-Stream transmitter: on start, streams MEM_DEPTH words read from a synchronous-read memory.
// Optional start-of-frame flag on m_axis_tuser when AXIS_TX_TUSER_EN is defined.
module axis_buffer_tx #(
  parameter int WIDTH      = 64,
  parameter int MEM_DEPTH  = 11,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [WIDTH-1:0]      mem_dout,
  input  logic                  m_axis_tready,
  output logic [WIDTH-1:0]      m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast
`ifdef AXIS_TX_TUSER_EN
  ,
  output logic                  m_axis_tuser
`endif
);

  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(MEM_DEPTH);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MEM_DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic               inflight_q, inflight_d;
  logic               out_vld_q, out_vld_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic               skid_vld_q, skid_vld_d;
  logic [WIDTH-1:0]   skid_data_q, skid_data_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               pop_s;
  logic               issue_s;
  logic               out_free_s;
  logic [2:0]         occ_s;

  // Occupancy counts the word returning from memory this cycle, so the two registers never overflow.
  always_comb begin
    pop_s      = out_vld_q && m_axis_tready;
    occ_s      = {2'b00, out_vld_q} + {2'b00, skid_vld_q} + {2'b00, inflight_q} - {2'b00, pop_s};
    issue_s    = (state_q == S_STREAM) && (rd_cnt_q < DEPTH_C) && (occ_s < 3'd2);
    out_free_s = !out_vld_q || pop_s;
  end

  always_comb begin
    state_d     = state_q;
    rd_cnt_d    = rd_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    inflight_d  = issue_s;
    out_vld_d   = out_vld_q;
    out_data_d  = out_data_q;
    skid_vld_d  = skid_vld_q;
    skid_data_d = skid_data_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_STREAM;
          rd_cnt_d   = {CNT_W{1'b0}};
          beat_cnt_d = {CNT_W{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_STREAM: begin
        if (issue_s) begin
          rd_cnt_d = rd_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          rd_cnt_d = rd_cnt_q;
        end
        if (pop_s) begin
          beat_cnt_d = beat_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          if (beat_cnt_q == LAST_BEAT) begin
            state_d = S_DONE;
          end else begin
            state_d = S_STREAM;
          end
        end else begin
          beat_cnt_d = beat_cnt_q;
        end
      end
      S_DONE: begin
        state_d    = S_IDLE;
        rd_cnt_d   = {CNT_W{1'b0}};
        beat_cnt_d = {CNT_W{1'b0}};
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The skid entry is always older than a returning word, so it refills the output first.
    if (out_free_s) begin
      if (skid_vld_q) begin
        out_vld_d  = 1'b1;
        out_data_d = skid_data_q;
        skid_vld_d = inflight_q;
        if (inflight_q) begin
          skid_data_d = mem_dout;
        end else begin
          skid_data_d = skid_data_q;
        end
      end else if (inflight_q) begin
        out_vld_d  = 1'b1;
        out_data_d = mem_dout;
      end else begin
        out_vld_d = 1'b0;
      end
    end else if (inflight_q) begin
      skid_vld_d  = 1'b1;
      skid_data_d = mem_dout;
    end else begin
      skid_vld_d = skid_vld_q;
    end

    busy_d = (state_d == S_STREAM);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q     <= S_IDLE;
      rd_cnt_q    <= {CNT_W{1'b0}};
      beat_cnt_q  <= {CNT_W{1'b0}};
      inflight_q  <= 1'b0;
      out_vld_q   <= 1'b0;
      out_data_q  <= {WIDTH{1'b0}};
      skid_vld_q  <= 1'b0;
      skid_data_q <= {WIDTH{1'b0}};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_cnt_q    <= rd_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      inflight_q  <= inflight_d;
      out_vld_q   <= out_vld_d;
      out_data_q  <= out_data_d;
      skid_vld_q  <= skid_vld_d;
      skid_data_q <= skid_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign mem_en        = issue_s;
  assign mem_addr      = rd_cnt_q[ADDR_WIDTH-1:0];
  assign m_axis_tdata  = out_data_q;
  assign m_axis_tvalid = out_vld_q;
  assign m_axis_tlast  = out_vld_q && (beat_cnt_q == LAST_BEAT);
`ifdef AXIS_TX_TUSER_EN
  assign m_axis_tuser  = out_vld_q && (beat_cnt_q == {CNT_W{1'b0}});
`endif

endmodule
